// File: rtl/crossover_trade_fsm.sv
// -----------------------------------------------------------------------------
// crossover_trade_fsm
//
// Purpose:
//   Sits after the 32-tap moving-average filter. Compares each raw price sample
//   against its filtered average and makes long-only buy/sell decisions. A
//   hysteresis margin and a run of confirming samples are both required before
//   a trade. The block also tracks the open position, the number of completed
//   round trips and the realised profit/loss.
//
// Handshake:
//   sample_valid is a one-way strobe with no backpressure. price and avg are
//   only looked at on cycles where sample_valid=1. On all other cycles every
//   counter and register holds its value, and the buy/sell/stop_hit pulses
//   drop back to 0.
//
// Ports:
//   clk          in   1      system clock, all logic on the rising edge
//   rst          in   1      synchronous reset, active-high
//   sample_valid in   1      price/avg are valid this cycle
//   price        in   WIDTH  raw price sample (unsigned)
//   avg          in   WIDTH  moving average for the same sample (unsigned)
//   buy          out  1      one-cycle pulse: position opened
//   sell         out  1      one-cycle pulse: position closed
//   long_pos     out  1      high while a position is held
//   state        out  2      FSM register: 0=WARMUP 1=FLAT 2=LONG 3=COOLDOWN
//   trade_count  out  8      completed round trips, saturates at 255
//   pnl          out  16     signed realised P&L, saturates at +32767/-32768
//   stop_hit     out  1      pulses together with sell when the stop-loss fired
//
// Configuration macro:
//   STOP_LOSS_EN  When defined, an open position is also closed as soon as
//                 price + STOP_DELTA <= entry. When undefined, no stop logic is
//                 built and stop_hit is tied to 0.
//
// Parameter limits: 1 <= WIDTH <= 15, WARMUP >= 1, CONFIRM >= 1, COOLDOWN >= 1.
// -----------------------------------------------------------------------------
module crossover_trade_fsm #(
  parameter int WIDTH      = 8,
  parameter int HYST       = 2,
  parameter int CONFIRM    = 3,
  parameter int WARMUP     = 32,
  parameter int COOLDOWN   = 4,
  parameter int STOP_DELTA = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               sample_valid,
  input  logic [WIDTH-1:0]   price,
  input  logic [WIDTH-1:0]   avg,
  output logic               buy,
  output logic               sell,
  output logic               long_pos,
  output logic [1:0]         state,
  output logic [7:0]         trade_count,
  output logic signed [15:0] pnl,
  output logic               stop_hit
);

  typedef enum logic [1:0] {
    ST_WARMUP   = 2'd0,
    ST_FLAT     = 2'd1,
    ST_LONG     = 2'd2,
    ST_COOLDOWN = 2'd3
  } state_t;

  localparam int WU_W = (WARMUP   < 1) ? 1 : $clog2(WARMUP + 1);
  localparam int CF_W = (CONFIRM  < 1) ? 1 : $clog2(CONFIRM + 1);
  localparam int CD_W = (COOLDOWN < 1) ? 1 : $clog2(COOLDOWN + 1);

  localparam logic [WIDTH:0] HYST_X = (WIDTH + 1)'(HYST);

  state_t                state_q, state_d;
  logic [WU_W-1:0]       wu_cnt_q, wu_cnt_d;
  logic [CF_W-1:0]       conf_q, conf_d;
  logic [CD_W-1:0]       cd_cnt_q, cd_cnt_d;
  logic [WIDTH-1:0]      entry_q, entry_d;
  logic                  buy_q, buy_d;
  logic                  sell_q, sell_d;
  logic [7:0]            count_q, count_d;
  logic signed [15:0]    pnl_q, pnl_d;

  // Compare and subtract one bit wider than the samples so that
  // avg + HYST and price + STOP_DELTA cannot wrap.
  logic [WIDTH:0]        price_x, avg_x, entry_x;
  logic                  above, below, stop_trig, conf_hit;
  logic signed [WIDTH:0] delta;
  logic signed [16:0]    pnl_sum;
  logic signed [15:0]    pnl_sat;
  logic [7:0]            count_sat;

  assign price_x  = {1'b0, price};
  assign avg_x    = {1'b0, avg};
  assign entry_x  = {1'b0, entry_q};
  assign above    = price_x >= avg_x + HYST_X;
  assign below    = avg_x >= price_x + HYST_X;
  // The confirm counter stops at CONFIRM-1. A qualifying sample seen at that
  // count completes the run.
  assign conf_hit = (conf_q == CF_W'(CONFIRM - 1));

`ifdef STOP_LOSS_EN
  localparam logic [WIDTH:0] STOP_X = (WIDTH + 1)'(STOP_DELTA);
  logic stop_q;

  assign stop_trig = (price_x + STOP_X) <= entry_x;

  // stop_hit goes high on the same sample that closes the position through
  // the stop. That is the LONG-state sell branch whenever stop_trig is set.
  always_ff @(posedge clk) begin
    if (rst) begin
      stop_q <= 1'b0;
    end else begin
      stop_q <= sample_valid && (state_q == ST_LONG) && stop_trig;
    end
  end
  assign stop_hit = stop_q;
`else
  logic unused_stop_delta;
  assign unused_stop_delta = (STOP_DELTA != 0);
  assign stop_trig = 1'b0;
  assign stop_hit  = 1'b0;
`endif

  // Realised trade result, sign-extended to 17 bits before it is added to
  // pnl, so the sum cannot overflow before it is clamped.
  assign delta   = $signed(price_x) - $signed(entry_x);
  assign pnl_sum = $signed({pnl_q[15], pnl_q}) + $signed({{(16 - WIDTH){delta[WIDTH]}}, delta});

  always_comb begin
    pnl_sat = pnl_sum[15:0];
    if (pnl_sum > 17'sd32767) begin
      pnl_sat = 16'sh7FFF;
    end else if (pnl_sum < -17'sd32768) begin
      pnl_sat = 16'sh8000;
    end
  end

  assign count_sat = (count_q == 8'hFF) ? count_q : count_q + 8'd1;

  // Next-state and next-output logic.
  always_comb begin
    state_d  = state_q;
    wu_cnt_d = wu_cnt_q;
    conf_d   = conf_q;
    cd_cnt_d = cd_cnt_q;
    entry_d  = entry_q;
    buy_d    = 1'b0;
    sell_d   = 1'b0;
    count_d  = count_q;
    pnl_d    = pnl_q;

    if (sample_valid) begin
      unique case (state_q)
        ST_WARMUP: begin
          // The sample that ends warmup is not evaluated.
          if (wu_cnt_q == WU_W'(WARMUP - 1)) begin
            wu_cnt_d = '0;
            state_d  = ST_FLAT;
          end else begin
            wu_cnt_d = wu_cnt_q + 1'b1;
          end
        end

        ST_FLAT: begin
          if (above && conf_hit) begin
            buy_d   = 1'b1;
            entry_d = price;
            conf_d  = '0;
            state_d = ST_LONG;
          end else if (above) begin
            conf_d = conf_q + 1'b1;
          end else begin
            conf_d = '0;
          end
        end

        ST_LONG: begin
          // A stop and a confirmed crossover on the same sample give a
          // single sell.
          if ((below && conf_hit) || stop_trig) begin
            sell_d  = 1'b1;
            pnl_d   = pnl_sat;
            count_d = count_sat;
            conf_d  = '0;
            state_d = ST_COOLDOWN;
          end else if (below) begin
            conf_d = conf_q + 1'b1;
          end else begin
            conf_d = '0;
          end
        end

        ST_COOLDOWN: begin
          if (cd_cnt_q == CD_W'(COOLDOWN - 1)) begin
            cd_cnt_d = '0;
            conf_d   = '0;
            state_d  = ST_FLAT;
          end else begin
            cd_cnt_d = cd_cnt_q + 1'b1;
          end
        end

        default: state_d = ST_WARMUP;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_WARMUP;
      wu_cnt_q <= '0;
      conf_q   <= '0;
      cd_cnt_q <= '0;
      entry_q  <= '0;
      buy_q    <= 1'b0;
      sell_q   <= 1'b0;
      count_q  <= 8'd0;
      pnl_q    <= 16'sd0;
    end else begin
      state_q  <= state_d;
      wu_cnt_q <= wu_cnt_d;
      conf_q   <= conf_d;
      cd_cnt_q <= cd_cnt_d;
      entry_q  <= entry_d;
      buy_q    <= buy_d;
      sell_q   <= sell_d;
      count_q  <= count_d;
      pnl_q    <= pnl_d;
    end
  end

  assign buy         = buy_q;
  assign sell        = sell_q;
  assign long_pos    = (state_q == ST_LONG);
  assign state       = state_q;
  assign trade_count = count_q;
  assign pnl         = pnl_q;

endmodule

// File: tb/tb_crossover_trade_fsm.sv
// -----------------------------------------------------------------------------
// tb_crossover_trade_fsm
//
// Drives crossover_trade_fsm with directed scenarios and then a random walk.
// Every cycle's outputs are checked against a trading model that uses plain
// integers. Uses the default parameters
// (HYST=2, CONFIRM=3, WARMUP=32, COOLDOWN=4, STOP_DELTA=8).
// -----------------------------------------------------------------------------
module tb_crossover_trade_fsm;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sample_valid = 1'b0;
  logic [7:0] price = 8'd0;
  logic [7:0] avg = 8'd0;
  logic buy, sell, long_pos, stop_hit;
  logic [1:0] state;
  logic [7:0] trade_count;
  logic signed [15:0] pnl;

  always #5 clk = ~clk;

  crossover_trade_fsm dut (
    .clk          (clk),
    .rst          (rst),
    .sample_valid (sample_valid),
    .price        (price),
    .avg          (avg),
    .buy          (buy),
    .sell         (sell),
    .long_pos     (long_pos),
    .state        (state),
    .trade_count  (trade_count),
    .pnl          (pnl),
    .stop_hit     (stop_hit)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  // Packed expected output word: {state[2], buy, sell, long_pos, stop_hit, count[8], pnl[16]}
  logic [29:0] exp_q[$];

  // Model of the trader: a mode number, sample counters and integer P&L.
  int m_mode, m_warm, m_run, m_cool, m_entry, m_pnl, m_trades;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step(input bit r, input bit v, input int p, input int a);
    bit e_buy, e_sell, e_stop, stop;
    e_buy = 0; e_sell = 0; e_stop = 0; stop = 0;
    if (r) begin
      m_mode = 0; m_warm = 0; m_run = 0; m_cool = 0;
      m_entry = 0; m_pnl = 0; m_trades = 0;
    end else if (v) begin
      case (m_mode)
        0: begin
          m_warm++;
          if (m_warm == 32) begin m_warm = 0; m_mode = 1; end
        end
        1: begin
          if (p >= a + 2) m_run++; else m_run = 0;
          if (m_run == 3) begin
            e_buy = 1; m_entry = p; m_run = 0; m_mode = 2;
          end
        end
        2: begin
`ifdef STOP_LOSS_EN
          stop = (p + 8 <= m_entry);
`endif
          if (a >= p + 2) m_run++; else m_run = 0;
          if (m_run == 3 || stop) begin
            e_sell = 1; e_stop = stop;
            m_pnl = m_pnl + (p - m_entry);
            if (m_pnl > 32767) m_pnl = 32767;
            if (m_pnl < -32768) m_pnl = -32768;
            if (m_trades < 255) m_trades++;
            m_run = 0; m_mode = 3;
          end
        end
        default: begin
          m_cool++;
          if (m_cool == 4) begin m_cool = 0; m_run = 0; m_mode = 1; end
        end
      endcase
    end
    exp_q.push_back({2'(m_mode), e_buy, e_sell, (m_mode == 2), e_stop,
                     8'(m_trades), 16'(m_pnl)});
  endtask

  task automatic compare_outputs();
    logic [29:0] e;
    e = exp_q.pop_front();
    check_eq("state",       {30'b0, state},       {30'b0, e[29:28]});
    check_eq("buy",         {31'b0, buy},         {31'b0, e[27]});
    check_eq("sell",        {31'b0, sell},        {31'b0, e[26]});
    check_eq("long_pos",    {31'b0, long_pos},    {31'b0, e[25]});
    check_eq("stop_hit",    {31'b0, stop_hit},    {31'b0, e[24]});
    check_eq("trade_count", {24'b0, trade_count}, {24'b0, e[23:16]});
    check_eq("pnl",         {16'b0, pnl},         {16'b0, e[15:0]});
  endtask

  // ---------------- driver tasks ----------------
  // Inputs change on the falling edge. Outputs are sampled 1 ns after the
  // rising edge.
  task automatic cycle(input bit r, input bit v, input logic [7:0] p, input logic [7:0] a);
    @(negedge clk);
    rst = r; sample_valid = v; price = p; avg = a;
    model_step(r, v, int'(p), int'(a));
    @(posedge clk);
    #1;
    compare_outputs();
  endtask

  task automatic sample(input logic [7:0] p, input logic [7:0] a);
    cycle(1'b0, 1'b1, p, a);
  endtask

  task automatic idle();
    cycle(1'b0, 1'b0, 8'd0, 8'd0);
  endtask

  task automatic do_reset();
    cycle(1'b1, 1'b0, 8'd0, 8'd0);
  endtask

  task automatic warmup();
    repeat (32) sample(8'd200, 8'd100);
  endtask

  // ---------------- stimulus ----------------
  int rw_avg, rw_off, rw_p, rw_sel;

  initial begin
    // Reset, then warmup: no buy during the first 31 samples.
    do_reset();
    check_eq("rst_state", {30'b0, state}, 32'd0);
    repeat (31) sample(8'd200, 8'd100);
    check_eq("t1_state31", {30'b0, state}, 32'd0);
    check_eq("t1_buy31", {31'b0, buy}, 32'd0);
    sample(8'd200, 8'd100);
    check_eq("t1_state32", {30'b0, state}, 32'd1);
    check_eq("t1_buy32", {31'b0, buy}, 32'd0);

    // A margin of 1 is inside the hysteresis band. A neutral sample clears the run.
    repeat (10) sample(8'd101, 8'd100);
    check_eq("t3_no_buy", {30'b0, state}, 32'd1);
    sample(8'd104, 8'd100); sample(8'd104, 8'd100); sample(8'd100, 8'd100);
    sample(8'd104, 8'd100); sample(8'd104, 8'd100);
    check_eq("t3_buy_early", {31'b0, buy}, 32'd0);
    sample(8'd104, 8'd100);
    check_eq("t3_buy", {31'b0, buy}, 32'd1);

    // Idle cycles inside the confirm run, then buy at 105 and sell at 95.
    do_reset();
    warmup();
    sample(8'd105, 8'd100); idle(); sample(8'd105, 8'd100); idle(); idle();
    sample(8'd105, 8'd100);
    check_eq("t2_buy", {31'b0, buy}, 32'd1);
    check_eq("t2_long", {31'b0, long_pos}, 32'd1);
    check_eq("t2_state", {30'b0, state}, 32'd2);
    idle();
    check_eq("t2_buy_pulse", {31'b0, buy}, 32'd0);
    repeat (3) sample(8'd95, 8'd100);
    check_eq("t4_sell", {31'b0, sell}, 32'd1);
    check_eq("t4_pnl", {16'b0, pnl}, 32'h0000FFF6);
    check_eq("t4_count", {24'b0, trade_count}, 32'd1);
    check_eq("t4_state", {30'b0, state}, 32'd3);
    repeat (4) sample(8'd120, 8'd100);
    check_eq("t4_cool_state", {30'b0, state}, 32'd1);
    check_eq("t4_cool_buy", {31'b0, buy}, 32'd0);
    repeat (3) sample(8'd120, 8'd100);
    check_eq("t4_rebuy", {31'b0, buy}, 32'd1);

    // Reset while long with pnl=-10: everything clears and no sell pulse.
    do_reset();
    check_eq("t6_rst_sell", {31'b0, sell}, 32'd0);
    check_eq("t6_rst_long", {31'b0, long_pos}, 32'd0);
    check_eq("t6_rst_pnl", {16'b0, pnl}, 32'd0);
    check_eq("t6_rst_count", {24'b0, trade_count}, 32'd0);

    // Stop-loss case: entry 105, then one sample at 97 (avg 90).
    warmup();
    repeat (3) sample(8'd105, 8'd100);
    sample(8'd97, 8'd90);
`ifdef STOP_LOSS_EN
    check_eq("t5_sell", {31'b0, sell}, 32'd1);
    check_eq("t5_stop", {31'b0, stop_hit}, 32'd1);
    check_eq("t5_pnl", {16'b0, pnl}, 32'h0000FFF8);
`else
    check_eq("t5_no_sell", {31'b0, sell}, 32'd0);
    check_eq("t5_still_long", {30'b0, state}, 32'd2);
`endif

    // P&L and trade count saturation: 258 round trips of +200.
    do_reset();
    warmup();
    repeat (258) begin
      repeat (3) sample(8'd20, 8'd10);
      repeat (3) sample(8'd220, 8'd250);
      repeat (4) sample(8'd20, 8'd10);
    end
    check_eq("t6_pnl_sat", {16'b0, pnl}, 32'h00007FFF);
    check_eq("t6_count_sat", {24'b0, trade_count}, 32'd255);

    // Random walk around a slowly moving average, with edge values,
    // idle cycles and occasional resets.
    do_reset();
    warmup();
    rw_avg = 128;
    repeat (3000) begin
      rw_sel = $urandom_range(0, 999);
      if (rw_sel < 2) begin
        do_reset();
      end else if (rw_sel < 200) begin
        idle();
      end else if (rw_sel < 215) begin
        sample((rw_sel[0]) ? 8'd255 : 8'd0, 8'(rw_avg));
      end else begin
        rw_avg = rw_avg + $urandom_range(0, 6) - 3;
        if (rw_avg < 0) rw_avg = 0;
        if (rw_avg > 255) rw_avg = 255;
        rw_off = $urandom_range(0, 24) - 12;
        rw_p = rw_avg + rw_off;
        if (rw_p < 0) rw_p = 0;
        if (rw_p > 255) rw_p = 255;
        sample(8'(rw_p), 8'(rw_avg));
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
